// File: rtl/beat_sequencer_ctrl.sv
// Run/stop controller around the one-hot instruction beat ring: start, single-step, halt,
// stall hold with a watchdog, and a retired-instruction-cycle counter.
module beat_sequencer_ctrl #(
  parameter int NBEATS    = 4,
  parameter int CNT_W     = 16,
  parameter int STALL_W   = 8,
  parameter int MAX_STALL = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              halt,
  input  logic              stall,
  input  logic              fault_clr,
  output logic [NBEATS-1:0] t,
  output logic              cycle_done,
  output logic              busy,
  output logic              fault,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_FAULT
  } state_e;

  localparam logic [NBEATS-1:0]  BEAT0      = NBEATS'(1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(MAX_STALL > 0 ? MAX_STALL - 1 : 0);
  localparam bit                 WD_ENABLE  = (MAX_STALL > 0);

  state_e             state, state_d;
  logic [NBEATS-1:0]  t_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [STALL_W-1:0] stall_cnt, stall_cnt_d;
  logic               halt_pend, halt_pend_d;
  logic               fault_d;
  logic               last_beat;
  logic               wd_trip;

  assign busy       = (state == ST_RUN) || (state == ST_STEP);
  assign last_beat  = t[NBEATS-1];
  assign cycle_done = busy & last_beat & ~stall;
  // Fires on the MAX_STALL-th consecutive stalled edge.
  assign wd_trip    = WD_ENABLE && stall && (stall_cnt == STALL_LAST);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state;
    t_d         = t;
    cnt_d       = instr_cnt;
    stall_cnt_d = stall_cnt;
    halt_pend_d = halt_pend;
    fault_d     = fault;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          t_d     = BEAT0;
        end else if (step) begin
          state_d = ST_STEP;
          t_d     = BEAT0;
        end
      end

      ST_RUN, ST_STEP: begin
        if (stall) begin
          if (wd_trip) begin
            state_d     = ST_FAULT;
            t_d         = '0;
            fault_d     = 1'b1;
            halt_pend_d = 1'b0;
            stall_cnt_d = '0;
          end else begin
            stall_cnt_d = stall_cnt + 1'b1;
            if (state == ST_RUN && halt && !last_beat) halt_pend_d = 1'b1;
          end
        end else begin
          stall_cnt_d = '0;
          if (last_beat) begin
            cnt_d = instr_cnt + 1'b1;
            if (state == ST_STEP || halt_pend || halt) begin
              state_d     = ST_IDLE;
              t_d         = '0;
              halt_pend_d = 1'b0;
            end else begin
              t_d = BEAT0;
            end
          end else begin
            t_d = {t[NBEATS-2:0], 1'b0};
            if (state == ST_RUN && halt) halt_pend_d = 1'b1;
          end
        end
      end

      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state     <= ST_IDLE;
      t         <= '0;
      instr_cnt <= '0;
      stall_cnt <= '0;
      halt_pend <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_d;
      t         <= t_d;
      instr_cnt <= cnt_d;
      stall_cnt <= stall_cnt_d;
      halt_pend <= halt_pend_d;
      fault     <= fault_d;
    end
  end

endmodule

// File: tb/tb_beat_sequencer_ctrl.sv
// Self-checking bench for beat_sequencer_ctrl: directed scenarios with literal expectations,
// then randomized control traffic compared every cycle against a beat-index reference model.
module tb_beat_sequencer_ctrl;

  localparam int NB = 4;
  localparam int CW = 4;
  localparam int SW = 8;
  localparam int MS = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, step = 1'b0, halt = 1'b0, stall = 1'b0, fault_clr = 1'b0;
  logic [NB-1:0] t;
  logic          cycle_done, busy, fault;
  logic [CW-1:0] instr_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  logic cd_seen;

  always #5 clk = ~clk;

  beat_sequencer_ctrl #(
    .NBEATS(NB), .CNT_W(CW), .STALL_W(SW), .MAX_STALL(MS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .halt(halt), .stall(stall),
    .fault_clr(fault_clr), .t(t), .cycle_done(cycle_done), .busy(busy), .fault(fault),
    .instr_cnt(instr_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks which beat is executing as an index, plus mode flags.
  bit m_valid = 0, m_active = 0, m_single = 0, m_fault = 0, m_pend = 0;
  int m_beat = 0, m_stalls = 0, m_retired = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_valid <= 1; m_active <= 0; m_single <= 0; m_fault <= 0; m_pend <= 0;
      m_beat <= 0; m_stalls <= 0; m_retired <= 0;
    end else if (m_valid) begin
      if (m_fault) begin
        if (fault_clr) m_fault <= 0;
      end else if (!m_active) begin
        if (start || step) begin
          m_active <= 1; m_single <= !start; m_beat <= 0;
        end
      end else if (stall) begin
        if (MS > 0 && m_stalls + 1 == MS) begin
          m_fault <= 1; m_active <= 0; m_pend <= 0; m_stalls <= 0;
        end else begin
          m_stalls <= m_stalls + 1;
          if (!m_single && halt && m_beat != NB - 1) m_pend <= 1;
        end
      end else begin
        m_stalls <= 0;
        if (m_beat == NB - 1) begin
          m_retired <= m_retired + 1;
          if (m_single || m_pend || halt) begin
            m_active <= 0; m_pend <= 0;
          end else begin
            m_beat <= 0;
          end
        end else begin
          m_beat <= m_beat + 1;
          if (!m_single && halt) m_pend <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (m_valid) begin
      check("t", 32'(t), m_active ? (32'd1 << m_beat) : 32'd0);
      check("busy", 32'(busy), 32'(m_active));
      check("fault", 32'(fault), 32'(m_fault));
      check("instr_cnt", 32'(instr_cnt), 32'(m_retired % (1 << CW)));
      check("cycle_done", 32'(cycle_done), 32'(m_active && m_beat == NB - 1 && !stall));
      check("t_onehot0", 32'($onehot0(t)), 32'd1);
    end
  end

  // One clock: drive inputs at the falling edge, note cycle_done, return just after the rising edge.
  task automatic step_clk(input bit r, input bit s, input bit p, input bit h, input bit st, input bit fc);
    @(negedge clk);
    rst = r; start = s; step = p; halt = h; stall = st; fault_clr = fc;
    #1 cd_seen = cycle_done;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step_clk(1, 0, 0, 0, 0, 0);
  endtask

  logic [3:0] ring [4];

  initial begin
    ring = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Reset and continuous run
    step_clk(0, 0, 0, 0, 0, 0);
    check("rst t", 32'(t), 0);
    check("rst cnt", 32'(instr_cnt), 0);
    check("rst busy", 32'(busy), 0);
    check("rst fault", 32'(fault), 0);
    step_clk(1, 1, 0, 0, 0, 0);
    check("run beat0", 32'(t), 32'(4'b0001));
    check("run busy", 32'(busy), 1);
    for (int c = 1; c <= 3; c++) begin
      for (int b = 1; b <= 4; b++) begin
        nop();
        check("run ring", 32'(t), 32'(ring[b % 4]));
        check("run cd", 32'(cd_seen), 32'(b == 4));
      end
      check("run cnt", 32'(instr_cnt), 32'(c));
    end

    // Halt during beat 1 finishes the cycle then idles
    nop();
    step_clk(1, 0, 0, 1, 0, 0);
    check("halt 0100", 32'(t), 32'(4'b0100));
    nop();
    check("halt 1000", 32'(t), 32'(4'b1000));
    nop();
    check("halt t0", 32'(t), 0);
    check("halt cd", 32'(cd_seen), 1);
    check("halt cnt", 32'(instr_cnt), 4);
    check("halt busy", 32'(busy), 0);
    nop();
    check("halt no beat0", 32'(t), 0);

    // Single step, twice
    step_clk(1, 0, 1, 0, 0, 0);
    check("step beat0", 32'(t), 32'(4'b0001));
    for (int b = 1; b <= 3; b++) nop();
    check("step 1000", 32'(t), 32'(4'b1000));
    nop();
    check("step t0", 32'(t), 0);
    check("step cnt", 32'(instr_cnt), 5);
    check("step busy", 32'(busy), 0);
    step_clk(1, 0, 1, 0, 0, 0);
    for (int b = 1; b <= 4; b++) nop();
    check("step2 cnt", 32'(instr_cnt), 6);
    check("step2 t0", 32'(t), 0);

    // Short stall holds the beat without faulting
    step_clk(1, 1, 0, 0, 0, 0);
    nop();
    nop();
    for (int i = 0; i < 3; i++) begin
      step_clk(1, 0, 0, 0, 1, 0);
      check("stall hold", 32'(t), 32'(4'b0100));
    end
    check("stall nofault", 32'(fault), 0);
    nop();
    check("stall resume", 32'(t), 32'(4'b1000));
    nop();
    check("stall cnt", 32'(instr_cnt), 7);

    // Watchdog: five stalled edges fault, clear, restart
    for (int i = 1; i <= 5; i++) begin
      step_clk(1, 0, 0, 0, 1, 0);
      check("wd fault", 32'(fault), 32'(i == 5));
      check("wd t", 32'(t), (i == 5) ? 0 : 32'(4'b0001));
    end
    check("wd busy", 32'(busy), 0);
    check("wd cnt", 32'(instr_cnt), 7);
    step_clk(1, 1, 0, 0, 0, 0);
    check("fault ign start", 32'(t), 0);
    step_clk(1, 1, 0, 0, 0, 1);
    check("clr fault", 32'(fault), 0);
    check("clr no start", 32'(t), 0);
    step_clk(1, 1, 0, 0, 0, 0);
    check("restart beat0", 32'(t), 32'(4'b0001));

    // Reset mid-cycle with a halt pending
    nop();
    step_clk(1, 0, 0, 1, 0, 0);
    check("pend 0100", 32'(t), 32'(4'b0100));
    step_clk(0, 0, 0, 0, 0, 0);
    check("midrst t", 32'(t), 0);
    check("midrst cnt", 32'(instr_cnt), 0);
    check("midrst busy", 32'(busy), 0);
    step_clk(1, 1, 0, 0, 0, 0);
    for (int b = 1; b <= 8; b++) begin
      nop();
      check("postrst ring", 32'(t), 32'(ring[b % 4]));
    end
    check("postrst cnt", 32'(instr_cnt), 2);
    step_clk(1, 0, 0, 1, 0, 0);
    for (int b = 0; b < 3; b++) nop();
    check("final idle", 32'(busy), 0);

    // Randomized traffic; stall bursts long enough to reach the watchdog
    begin
      int burst;
      bit r_n, st;
      burst = 0;
      for (int i = 0; i < 3000; i++) begin
        r_n = ($urandom_range(99) != 0);
        if (burst == 0 && $urandom_range(19) == 0) burst = $urandom_range(8, 1);
        st = (burst > 0) || ($urandom_range(3) == 0);
        if (burst > 0) burst--;
        step_clk(r_n, $urandom_range(9) == 0, $urandom_range(9) == 0,
                 $urandom_range(7) == 0, st, $urandom_range(4) == 0);
      end
    end

    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
